dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single 48-bit data memory (dmem) between two requesters: the CPU memory stage and a DMA/loader engine.
- The CPU has fixed priority. A starvation counter guarantees the DMA one grant after STARVE_MAX consecutive CPU grants while the DMA waits.
- Memory commands are registered. Read data returns to the winning requester with a fixed two-cycle latency.
- Sits between the cpu (ALUOutM / WriteDataM / MemWriteM / ReadDataM) and dmem (A / WD / WE / RD).

Parameters:
- WIDTH, 48, data and address width.
- STARVE_MAX, 4, consecutive CPU grants allowed while DmaReq is pending before the DMA is forced through (legal range 1..15).

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- CpuReq  in  1  CPU memory access request.
- CpuWE  in  1  1 = write, 0 = read.
- CpuAddr  in  WIDTH  CPU address.
- CpuWD  in  WIDTH  CPU write data.
- CpuStall  out  1  combinational; CpuReq high and not granted this cycle.
- CpuRD  out  WIDTH  CPU read data.
- CpuValid  out  1  CpuRD valid, one-cycle pulse.
- DmaReq  in  1  DMA request; held until DmaGnt.
- DmaWE  in  1  DMA write enable.
- DmaAddr  in  WIDTH  DMA address.
- DmaWD  in  WIDTH  DMA write data.
- DmaGnt  out  1  combinational; DMA request accepted this cycle.
- DmaRD  out  WIDTH  DMA read data.
- DmaValid  out  1  DmaRD valid, one-cycle pulse.
- MemWE  out  1  registered write enable to dmem.
- MemA  out  WIDTH  registered address to dmem.
- MemWD  out  WIDTH  registered write data to dmem.
- MemRD  in  WIDTH  dmem combinational read data.

Behaviour:
- Reset (Reset=0, asynchronous):
  - MemWE=0, MemA=0, MemWD=0.
  - CpuRD=0, DmaRD=0, CpuValid=0, DmaValid=0.
  - Starvation counter=0, response pipeline owners=OWN_NONE.
  - CpuStall and DmaGnt are forced 0 while in reset.
- Grant, cycle N (combinational):
  - If DmaReq and (not CpuReq or starve_cnt==STARVE_MAX), grant the DMA.
  - Else if CpuReq, grant the CPU.
  - Else grant none.
  - CpuStall = CpuReq and not cpu_gnt.
  - DmaGnt = dma_gnt.
- Issue, edge ending cycle N:
  - MemA, MemWD and MemWE are loaded from the winner.
  - If there is no winner, MemWE=0 and MemA/MemWD hold.
  - Stage-1 owner is set to the winner only for reads. Writes and idle cycles set OWN_NONE.
- Memory access, cycle N+1: MemRD is valid for the address in MemA.
- Response, edge ending cycle N+1:
  - MemRD is captured into CpuRD or DmaRD, selected by the stage-1 owner.
  - The matching Valid asserts for cycle N+2 only; the other Valid is 0.
  - The non-selected RD register holds its value.
- Latency: read grant at N -> Valid in cycle N+2. Writes commit to dmem at the edge ending N+1; they produce no Valid.
- Throughput: one access per cycle; back-to-back grants are legal.
- Starvation counter (4 bits):
  - CPU granted while DmaReq high: increment, saturating at STARVE_MAX.
  - DMA granted: clear.
  - DmaReq low: clear.
- Boundary conditions:
  - Simultaneous CpuReq and DmaReq with starve_cnt<STARVE_MAX: CPU wins, DMA waits with DmaGnt=0.
  - starve_cnt==STARVE_MAX: DMA wins for exactly one cycle and CpuStall=1. Next cycle the CPU regains priority.
  - A request changing while it is not granted has no effect; the arbiter samples inputs only at grant.
  - Reset mid-operation: in-flight responses are dropped with no Valid pulse. Any write already registered on MemWE is cleared, so dmem does not see it after reset deassertion.
  - Reset deassertion is synchronous to CLK at the integration level. No grant occurs in the first cycle after deassertion unless a request is high.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - typedef enum logic [1:0] owner_e {OWN_NONE, OWN_CPU, OWN_DMA};
  - localparam STARVE_W=4.
- Sub-module arb_prio_starve holds the grant logic plus the starvation counter. Inputs: CLK, Reset, CpuReq, DmaReq. Outputs: cpu_gnt, dma_gnt.
- The top level holds the issue registers and the response pipeline.

Test Plan:
- Reset: hold Reset=0 while requests toggle -> all outputs 0 and CpuStall=DmaGnt=0. Release, then CpuReq read of addr 0x10 -> MemA=0x10 after one edge.
- CPU read latency: preload dmem[0x20]=48'h0000_DEAD_BEEF. CpuReq read 0x20 at cycle N -> CpuValid=1 with CpuRD=0x0000DEADBEEF in cycle N+2 only; DmaValid stays 0.
- Starvation: CpuReq and DmaReq both held high continuously with STARVE_MAX=4 -> grant pattern CPU, CPU, CPU, CPU, DMA, repeating. CpuStall=1 exactly on each DMA cycle.
- Write then read: DMA writes 0x30=48'h123456789ABC, then CPU reads 0x30 next cycle -> CpuRD=0x123456789ABC two cycles after the CPU grant. No Valid pulse for the write.
- Reset mid-flight: CPU read granted at N, Reset=0 asserted during N+1 -> no CpuValid in N+2 and the counter reads 0. The first post-reset DMA request is granted immediately when CpuReq=0.
- Idle: no requests for 10 cycles -> MemWE=0 throughout, MemA unchanged, no Valid pulses.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   owner_e  : which requester owns a read response in flight
//   STARVE_W : width of the DMA starvation counter
package dmem_arb_pkg;

    localparam int unsigned STARVE_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DMA
    } owner_e;

endpackage

// File: rtl/arb_prio_starve.sv
// Fixed-priority CPU/DMA grant logic with a DMA starvation guard.
// Ports:
//   CLK, Reset      : clock, asynchronous active-low reset
//   CpuReq, DmaReq  : requests from the two masters
//   cpu_gnt, dma_gnt: combinational one-hot (or zero) grant for this cycle
module arb_prio_starve
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic CLK,
    input  logic Reset,
    input  logic CpuReq,
    input  logic DmaReq,
    output logic cpu_gnt,
    output logic dma_gnt
);

    localparam logic [STARVE_W-1:0] StarveMax = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] cnt_q, cnt_d;
    logic                starved;

    always_comb begin
        starved = (cnt_q == StarveMax);
        // Grants are held low during reset so nothing is accepted then.
        dma_gnt = Reset & DmaReq & (~CpuReq | starved);
        cpu_gnt = Reset & CpuReq & ~dma_gnt;

        // Count CPU wins only while the DMA is actually waiting.
        cnt_d = cnt_q;
        if (!DmaReq || dma_gnt) begin
            cnt_d = '0;
        end else if (cpu_gnt && !starved) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the CPU memory stage and a DMA engine.
// Commands to memory are registered; read data returns to the winning
// requester two cycles after its grant.
// Ports:
//   CLK, Reset                        : clock, asynchronous active-low reset
//   CpuReq/CpuWE/CpuAddr/CpuWD        : CPU request
//   CpuStall                          : CPU request not granted this cycle
//   CpuRD/CpuValid                    : CPU read response
//   DmaReq/DmaWE/DmaAddr/DmaWD        : DMA request (held until DmaGnt)
//   DmaGnt                            : DMA request accepted this cycle
//   DmaRD/DmaValid                    : DMA read response
//   MemWE/MemA/MemWD                  : registered memory command
//   MemRD                             : combinational memory read data
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned WIDTH      = 48,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             CpuReq,
    input  logic             CpuWE,
    input  logic [WIDTH-1:0] CpuAddr,
    input  logic [WIDTH-1:0] CpuWD,
    output logic             CpuStall,
    output logic [WIDTH-1:0] CpuRD,
    output logic             CpuValid,
    input  logic             DmaReq,
    input  logic             DmaWE,
    input  logic [WIDTH-1:0] DmaAddr,
    input  logic [WIDTH-1:0] DmaWD,
    output logic             DmaGnt,
    output logic [WIDTH-1:0] DmaRD,
    output logic             DmaValid,
    output logic             MemWE,
    output logic [WIDTH-1:0] MemA,
    output logic [WIDTH-1:0] MemWD,
    input  logic [WIDTH-1:0] MemRD
);

    logic cpu_gnt, dma_gnt;

    arb_prio_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .CLK     (CLK),
        .Reset   (Reset),
        .CpuReq  (CpuReq),
        .DmaReq  (DmaReq),
        .cpu_gnt (cpu_gnt),
        .dma_gnt (dma_gnt)
    );

    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_a_q, mem_a_d;
    logic [WIDTH-1:0] mem_wd_q, mem_wd_d;
    owner_e           own_q, own_d;
    logic [WIDTH-1:0] cpu_rd_q, cpu_rd_d;
    logic [WIDTH-1:0] dma_rd_q, dma_rd_d;
    logic             cpu_valid_q, cpu_valid_d;
    logic             dma_valid_q, dma_valid_d;

    always_comb begin
        // Issue stage: address/data hold when idle, only WE drops.
        mem_we_d = 1'b0;
        mem_a_d  = mem_a_q;
        mem_wd_d = mem_wd_q;
        own_d    = OWN_NONE;
        if (cpu_gnt) begin
            mem_we_d = CpuWE;
            mem_a_d  = CpuAddr;
            mem_wd_d = CpuWD;
            own_d    = CpuWE ? OWN_NONE : OWN_CPU;
        end else if (dma_gnt) begin
            mem_we_d = DmaWE;
            mem_a_d  = DmaAddr;
            mem_wd_d = DmaWD;
            own_d    = DmaWE ? OWN_NONE : OWN_DMA;
        end

        // Response stage: MemRD belongs to the command issued last cycle.
        cpu_valid_d = (own_q == OWN_CPU);
        dma_valid_d = (own_q == OWN_DMA);
        cpu_rd_d    = cpu_valid_d ? MemRD : cpu_rd_q;
        dma_rd_d    = dma_valid_d ? MemRD : dma_rd_q;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            mem_we_q    <= 1'b0;
            mem_a_q     <= '0;
            mem_wd_q    <= '0;
            own_q       <= OWN_NONE;
            cpu_rd_q    <= '0;
            dma_rd_q    <= '0;
            cpu_valid_q <= 1'b0;
            dma_valid_q <= 1'b0;
        end else begin
            mem_we_q    <= mem_we_d;
            mem_a_q     <= mem_a_d;
            mem_wd_q    <= mem_wd_d;
            own_q       <= own_d;
            cpu_rd_q    <= cpu_rd_d;
            dma_rd_q    <= dma_rd_d;
            cpu_valid_q <= cpu_valid_d;
            dma_valid_q <= dma_valid_d;
        end
    end

    assign CpuStall = CpuReq & ~cpu_gnt & Reset;
    assign DmaGnt   = dma_gnt;
    assign MemWE    = mem_we_q;
    assign MemA     = mem_a_q;
    assign MemWD    = mem_wd_q;
    assign CpuRD    = cpu_rd_q;
    assign CpuValid = cpu_valid_q;
    assign DmaRD    = dma_rd_q;
    assign DmaValid = dma_valid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level model (grant rule, response queue, shadow memory).
module tb_dmem_arbiter;

    localparam int W          = 48;
    localparam int STARVE_MAX = 4;

    logic         CLK = 1'b0;
    logic         Reset;
    logic         CpuReq, CpuWE, DmaReq, DmaWE;
    logic [W-1:0] CpuAddr, CpuWD, DmaAddr, DmaWD;
    logic         CpuStall, CpuValid, DmaGnt, DmaValid, MemWE;
    logic [W-1:0] CpuRD, DmaRD, MemA, MemWD, MemRD;

    dmem_arbiter #(
        .WIDTH      (W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .CpuReq   (CpuReq),
        .CpuWE    (CpuWE),
        .CpuAddr  (CpuAddr),
        .CpuWD    (CpuWD),
        .CpuStall (CpuStall),
        .CpuRD    (CpuRD),
        .CpuValid (CpuValid),
        .DmaReq   (DmaReq),
        .DmaWE    (DmaWE),
        .DmaAddr  (DmaAddr),
        .DmaWD    (DmaWD),
        .DmaGnt   (DmaGnt),
        .DmaRD    (DmaRD),
        .DmaValid (DmaValid),
        .MemWE    (MemWE),
        .MemA     (MemA),
        .MemWD    (MemWD),
        .MemRD    (MemRD)
    );

    always #5 CLK = ~CLK;

    // Memory stand-in: 64 words, indexed by the low address bits.
    logic [W-1:0] mem [64];
    assign MemRD = mem[MemA[5:0]];
    always @(posedge CLK) if (MemWE) mem[MemA[5:0]] = MemWD;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        int           due;
        bit           cpu;
        logic [W-1:0] data;
    } resp_t;

    logic [W-1:0] ref_mem [64];
    resp_t        rq[$];
    int           cyc = 0;
    int           m_streak = 0;
    bit           pw_v = 0;
    logic [5:0]   pw_a;
    logic [W-1:0] pw_d;
    logic         e_we = 0;
    logic [W-1:0] e_a = '0, e_wd = '0, e_crd = '0, e_drd = '0;

    always @(negedge CLK) begin
        bit           ecv, edv, gd, gc, we;
        logic [W-1:0] a, wd;
        resp_t        it;
        if (!Reset) begin
            chk("rst_ctl", {43'd0, CpuStall, DmaGnt, CpuValid, DmaValid, MemWE}, '0);
            chk("rst_mem_a", MemA, '0);
            chk("rst_mem_wd", MemWD, '0);
            chk("rst_cpu_rd", CpuRD, '0);
            chk("rst_dma_rd", DmaRD, '0);
            m_streak = 0;
            rq.delete();
            pw_v  = 0;
            e_we  = 0;
            e_a   = '0;
            e_wd  = '0;
            e_crd = '0;
            e_drd = '0;
        end else begin
            // The write granted last cycle commits at the end of this one.
            if (pw_v) ref_mem[pw_a] = pw_d;
            pw_v = 0;
            ecv  = 0;
            edv  = 0;
            if (rq.size() != 0 && rq[0].due == cyc) begin
                it = rq.pop_front();
                if (it.cpu) begin
                    ecv   = 1;
                    e_crd = it.data;
                end else begin
                    edv   = 1;
                    e_drd = it.data;
                end
            end
            chk("cpu_valid", CpuValid, ecv);
            chk("dma_valid", DmaValid, edv);
            chk("cpu_rd", CpuRD, e_crd);
            chk("dma_rd", DmaRD, e_drd);
            chk("mem_we", MemWE, e_we);
            chk("mem_a", MemA, e_a);
            chk("mem_wd", MemWD, e_wd);

            gd = DmaReq && (!CpuReq || m_streak >= STARVE_MAX);
            gc = CpuReq && !gd;
            chk("dma_gnt", DmaGnt, gd);
            chk("cpu_stall", CpuStall, CpuReq && !gc);

            if (!DmaReq || gd) m_streak = 0;
            else if (gc && m_streak < STARVE_MAX) m_streak++;

            if (gc || gd) begin
                we   = gc ? CpuWE : DmaWE;
                a    = gc ? CpuAddr : DmaAddr;
                wd   = gc ? CpuWD : DmaWD;
                e_we = we;
                e_a  = a;
                e_wd = wd;
                if (we) begin
                    pw_v = 1;
                    pw_a = a[5:0];
                    pw_d = wd;
                end else begin
                    rq.push_back('{cyc + 2, gc, ref_mem[a[5:0]]});
                end
            end else begin
                e_we = 0;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    function automatic logic [W-1:0] rnd48();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        CpuReq = 0; CpuWE = 0; CpuAddr = '0; CpuWD = '0;
        DmaReq = 0; DmaWE = 0; DmaAddr = '0; DmaWD = '0;
    endtask

    initial begin
        logic [W-1:0] v;
        bit           dma_taken;
        Reset = 0;
        idle_in();
        for (int i = 0; i < 64; i++) begin
            v          = rnd48();
            mem[i]     = v;
            ref_mem[i] = v;
        end
        mem[6'h20]     = 48'h0000_DEAD_BEEF;
        ref_mem[6'h20] = 48'h0000_DEAD_BEEF;

        // Requests toggling under reset must be ignored.
        for (int k = 0; k < 4; k++) begin
            step();
            CpuReq = k[0];
            DmaReq = ~k[0];
            @(negedge CLK);
            chk("rst_stall", CpuStall, 0);
            chk("rst_dmagnt", DmaGnt, 0);
            chk("rst_mema", MemA, 0);
            chk("rst_cvalid", CpuValid, 0);
        end

        step(); Reset = 1; idle_in(); CpuReq = 1; CpuAddr = 48'h10;
        @(negedge CLK); chk("first_stall", CpuStall, 0);
        step(); idle_in();
        @(negedge CLK); chk("mema_0x10", MemA, 48'h10); chk("mema_0x10_we", MemWE, 0);
        step();
        @(negedge CLK); chk("cvalid_0x10", CpuValid, 1);

        // CPU read latency.
        step(); CpuReq = 1; CpuAddr = 48'h20;
        @(negedge CLK);
        step(); idle_in();
        @(negedge CLK); chk("lat_n1_valid", CpuValid, 0);
        step();
        @(negedge CLK);
        chk("lat_n2_valid", CpuValid, 1);
        chk("lat_n2_rd", CpuRD, 48'h0000_DEAD_BEEF);
        chk("lat_n2_dvalid", DmaValid, 0);
        step();
        @(negedge CLK); chk("lat_n3_valid", CpuValid, 0);

        // Starvation: CPU x4 then DMA, repeating.
        for (int k = 0; k < 10; k++) begin
            step();
            CpuReq = 1; CpuWE = 0; CpuAddr = 48'(k);
            DmaReq = 1; DmaWE = 0; DmaAddr = 48'(64 + k);
            @(negedge CLK);
            chk("starve_gnt", DmaGnt, (k % 5 == 4));
            chk("starve_stall", CpuStall, (k % 5 == 4));
        end
        step(); idle_in();
        @(negedge CLK);

        // DMA write followed by CPU read of the same word.
        step(); DmaReq = 1; DmaWE = 1; DmaAddr = 48'h30; DmaWD = 48'h1234_5678_9ABC;
        @(negedge CLK); chk("wr_dma_gnt", DmaGnt, 1);
        step(); idle_in(); CpuReq = 1; CpuAddr = 48'h30;
        @(negedge CLK); chk("wr_memwe", MemWE, 1); chk("wr_mema", MemA, 48'h30);
        step(); idle_in();
        @(negedge CLK); chk("wr_no_cvalid", CpuValid, 0); chk("wr_no_dvalid", DmaValid, 0);
        step();
        @(negedge CLK); chk("rd_after_wr_valid", CpuValid, 1);
        chk("rd_after_wr_data", CpuRD, 48'h1234_5678_9ABC);

        // Build streak to 3 ending in a CPU read, then reset mid-flight.
        for (int k = 0; k < 3; k++) begin
            step(); CpuReq = 1; CpuWE = 0; CpuAddr = 48'h20; DmaReq = 1; DmaWE = 0;
            @(negedge CLK); chk("pre_rst_gnt", DmaGnt, 0);
        end
        step(); Reset = 0; idle_in();
        @(negedge CLK); chk("flight_n1_valid", CpuValid, 0);
        // Cleared counter: four CPU grants before the DMA is forced.
        for (int k = 0; k < 5; k++) begin
            step(); Reset = 1; CpuReq = 1; DmaReq = 1;
            @(negedge CLK);
            if (k == 0) chk("flight_n2_valid", CpuValid, 0);
            chk("post_rst_starve", DmaGnt, (k == 4));
        end
        step(); Reset = 0; idle_in();
        @(negedge CLK);
        step(); Reset = 1; DmaReq = 1; DmaWE = 1; DmaAddr = 48'h44; DmaWD = 48'hA5;
        @(negedge CLK); chk("post_rst_dma_gnt", DmaGnt, 1);

        // Idle.
        for (int k = 0; k < 10; k++) begin
            step(); idle_in();
            @(negedge CLK);
            if (k > 0) chk("idle_we", MemWE, 0);
            chk("idle_mema", MemA, 48'h44);
            chk("idle_cvalid", CpuValid, 0);
            chk("idle_dvalid", DmaValid, 0);
        end

        // Random traffic; the DMA holds its request until granted.
        dma_taken = 0;
        for (int n = 0; n < 3000; n++) begin
            step();
            Reset   = ($urandom_range(0, 299) != 0);
            CpuReq  = ($urandom_range(0, 2) != 0);
            CpuWE   = $urandom_range(0, 1) == 1;
            CpuAddr = rnd48();
            CpuWD   = rnd48();
            if (!DmaReq || dma_taken) begin
                DmaReq  = $urandom_range(0, 1) == 1;
                DmaWE   = $urandom_range(0, 1) == 1;
                DmaAddr = rnd48();
                DmaWD   = rnd48();
            end
            @(negedge CLK);
            dma_taken = DmaGnt;
        end

        step(); idle_in();
        @(negedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
